// File: rtl/skin_pkg.sv
// Shared definitions for the skin-mask pipeline: FSM encodings, default
// thresholds and the saturating subtract used to form the U/V chroma terms.
package skin_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_READOUT = 2'd2;

  localparam int U_LO_DEF  = 26;
  localparam int U_HI_DEF  = 74;
  localparam int V_MAX_DEF = 255;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/skin_classifier.sv
// Combinational skin decision: exclusive U window on R-G, optional inclusive
// V ceiling on B-G, both differences saturated at zero.
module skin_classifier
  import skin_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int USE_V       = 0
) (
  input  logic [COLOR_DEPTH-1:0] r,
  input  logic [COLOR_DEPTH-1:0] g,
  input  logic [COLOR_DEPTH-1:0] b,
  input  logic [COLOR_DEPTH-1:0] u_lo,
  input  logic [COLOR_DEPTH-1:0] u_hi,
  input  logic [COLOR_DEPTH-1:0] v_max,
  output logic                   skin
);

  logic [COLOR_DEPTH-1:0] u;
  logic [COLOR_DEPTH-1:0] v;

  assign u = COLOR_DEPTH'(sat_sub(32'(r), 32'(g)));
  assign v = COLOR_DEPTH'(sat_sub(32'(b), 32'(g)));

  assign skin = (u > u_lo) && (u < u_hi) && ((USE_V == 0) || (v <= v_max));

endmodule

// File: rtl/skin_mask_framer.sv
// Classifies a raster RGB frame into a 1-bit skin mask, keeps frame
// statistics, and replays the stored mask under ready/valid backpressure.
module skin_mask_framer
  import skin_pkg::*;
#(
  parameter int WIDTH       = 256,
  parameter int DEPTH       = 256,
  parameter int COLOR_DEPTH = 8,
  parameter int USE_V       = 0,
  parameter int X_W         = $clog2(WIDTH),
  parameter int Y_W         = $clog2(DEPTH),
  parameter int CNT_W       = $clog2(WIDTH*DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [COLOR_DEPTH-1:0] in_r,
  input  logic [COLOR_DEPTH-1:0] in_g,
  input  logic [COLOR_DEPTH-1:0] in_b,
  input  logic [COLOR_DEPTH-1:0] u_lo,
  input  logic [COLOR_DEPTH-1:0] u_hi,
  input  logic [COLOR_DEPTH-1:0] v_max,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       skin_count,
  output logic [CNT_W+X_W-1:0]   sum_x,
  output logic [CNT_W+Y_W-1:0]   sum_y,
  output logic                   bbox_valid,
  output logic [X_W-1:0]         min_x,
  output logic [X_W-1:0]         max_x,
  output logic [Y_W-1:0]         min_y,
  output logic [Y_W-1:0]         max_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_pixel,
  output logic                   out_last
);

  localparam int N      = WIDTH * DEPTH;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;

  logic [1:0]             state;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;
  logic [ADDR_W-1:0]      rd_idx;
  logic [COLOR_DEPTH-1:0] u_lo_q, u_hi_q, v_max_q;

  logic                   pix_skin, take, hit, last_px;
  logic                   fire, last_beat, rd_en, rd_q;

  logic [CNT_W-1:0]       acc_cnt,  acc_cnt_n;
  logic [CNT_W+X_W-1:0]   acc_sx,   acc_sx_n;
  logic [CNT_W+Y_W-1:0]   acc_sy,   acc_sy_n;
  logic [X_W-1:0]         acc_minx, acc_minx_n, acc_maxx, acc_maxx_n;
  logic [Y_W-1:0]         acc_miny, acc_miny_n, acc_maxy, acc_maxy_n;

  logic                   mem [N];

  skin_classifier #(
    .COLOR_DEPTH(COLOR_DEPTH),
    .USE_V      (USE_V)
  ) u_cls (
    .r    (in_r),
    .g    (in_g),
    .b    (in_b),
    .u_lo (u_lo_q),
    .u_hi (u_hi_q),
    .v_max(v_max_q),
    .skin (pix_skin)
  );

  assign take    = (state == ST_RECEIVE) && in_valid;
  assign hit     = take && pix_skin;
  assign last_px = (x == X_W'(WIDTH - 1)) && (y == Y_W'(DEPTH - 1));
  assign busy    = (state != ST_IDLE);

  // Running statistics including the pixel being accepted this cycle, so the
  // final pixel lands in the outputs on the same edge that raises frame_done.
  always_comb begin
    acc_cnt_n  = acc_cnt;
    acc_sx_n   = acc_sx;
    acc_sy_n   = acc_sy;
    acc_minx_n = acc_minx;
    acc_maxx_n = acc_maxx;
    acc_miny_n = acc_miny;
    acc_maxy_n = acc_maxy;
    if (hit) begin
      acc_cnt_n  = acc_cnt + CNT_W'(1);
      acc_sx_n   = acc_sx + (CNT_W+X_W)'(x);
      acc_sy_n   = acc_sy + (CNT_W+Y_W)'(y);
      acc_minx_n = (x < acc_minx) ? x : acc_minx;
      acc_maxx_n = (x > acc_maxx) ? x : acc_maxx;
      acc_miny_n = (y < acc_miny) ? y : acc_miny;
      acc_maxy_n = (y > acc_maxy) ? y : acc_maxy;
    end
  end

  // rd_addr indexes the beat currently presented; the RAM is only re-read on
  // a transfer, so the registered read data holds steady through stalls.
  assign fire      = out_valid && out_ready;
  assign last_beat = (rd_addr == ADDR_W'(N - 1));
  assign rd_en     = (state == ST_READOUT) && (!out_valid || (fire && !last_beat));
  assign rd_idx    = out_valid ? rd_addr + ADDR_W'(1) : rd_addr;
  assign out_pixel = out_valid && rd_q;
  assign out_last  = out_valid && last_beat;

  always_ff @(posedge clk) begin
    if (take && !rst) mem[wr_addr] <= pix_skin;
    if (rd_en)        rd_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      u_lo_q     <= COLOR_DEPTH'(U_LO_DEF);
      u_hi_q     <= COLOR_DEPTH'(U_HI_DEF);
      v_max_q    <= COLOR_DEPTH'(V_MAX_DEF);
      acc_cnt    <= '0;
      acc_sx     <= '0;
      acc_sy     <= '0;
      acc_minx   <= '1;
      acc_maxx   <= '0;
      acc_miny   <= '1;
      acc_maxy   <= '0;
      frame_done <= 1'b0;
      skin_count <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      bbox_valid <= 1'b0;
      min_x      <= '0;
      max_x      <= '0;
      min_y      <= '0;
      max_y      <= '0;
      out_valid  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RECEIVE;
            x        <= '0;
            y        <= '0;
            wr_addr  <= '0;
            acc_cnt  <= '0;
            acc_sx   <= '0;
            acc_sy   <= '0;
            acc_minx <= '1;
            acc_maxx <= '0;
            acc_miny <= '1;
            acc_maxy <= '0;
            u_lo_q   <= u_lo;
            u_hi_q   <= u_hi;
            v_max_q  <= v_max;
          end
        end
        ST_RECEIVE: begin
          if (in_valid) begin
            acc_cnt  <= acc_cnt_n;
            acc_sx   <= acc_sx_n;
            acc_sy   <= acc_sy_n;
            acc_minx <= acc_minx_n;
            acc_maxx <= acc_maxx_n;
            acc_miny <= acc_miny_n;
            acc_maxy <= acc_maxy_n;
            wr_addr  <= wr_addr + ADDR_W'(1);
            if (last_px) begin
              state      <= ST_READOUT;
              frame_done <= 1'b1;
              rd_addr    <= '0;
              skin_count <= acc_cnt_n;
              sum_x      <= acc_sx_n;
              sum_y      <= acc_sy_n;
              bbox_valid <= (acc_cnt_n != '0);
              min_x      <= (acc_cnt_n != '0) ? acc_minx_n : '0;
              max_x      <= (acc_cnt_n != '0) ? acc_maxx_n : '0;
              min_y      <= (acc_cnt_n != '0) ? acc_miny_n : '0;
              max_y      <= (acc_cnt_n != '0) ? acc_maxy_n : '0;
            end else if (x == X_W'(WIDTH - 1)) begin
              x <= '0;
              y <= y + Y_W'(1);
            end else begin
              x <= x + X_W'(1);
            end
          end
        end
        ST_READOUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (last_beat) begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
